gate_stim_checker: RTL
======================

Name: gate_stim_checker

Overview:
- Self-checking stimulus stage for the 2-input gate blocks (A, B -> Y).
- Drives the gate's A/B inputs through all four input combinations (00, 01, 10, 11) and holds each one for a fixed dwell time.
- Samples the gate's Y output at a fixed settle point and compares it with a parameterised expected truth table.
- Reports per-vector mismatches, an error count and an overall pass flag, so gate benches become self-checking instead of waveform-inspected.

Parameters:
- DWELL, 4: clock cycles each input vector is held. Legal range ≥2.
- SETTLE, 1: cycle offset within the dwell at which Y is sampled. Legal range 0..DWELL-1.
- EXP_TT, 4'b1000: expected truth table. Bit i is the expected Y for {A,B}=i. The default is AND.

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; accepted only in IDLE
- Y  in  1  output of gate under test (combinational from A/B)
- A  out  1  gate input A; equals vec_idx[1]
- B  out  1  gate input B; equals vec_idx[0]
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse in FINISH
- pass  out  1  sweep result; held until next accepted start
- err_cnt  out  3  number of mismatching vectors, 0..4
- fail_mask  out  4  bit i set if vector i mismatched
- vec_idx  out  2  current vector index

Behaviour:
- Reset:
  - Synchronous; dominates start and all other inputs.
  - Next edge: state=IDLE; A=B=busy=done=pass=0; err_cnt=0, fail_mask=0, vec_idx=0, dwell counter dcnt=0.
- Registers:
  - All outputs are registered.
  - dcnt width is $clog2(DWELL).
- States: IDLE, RUN, FINISH.
- IDLE:
  - On start=1 at an edge -> RUN.
  - At that edge: vec_idx=0, dcnt=0, fail_mask=0, err_cnt=0, pass=0, busy=1.
  - start=0 -> remain in IDLE; outputs hold.
- RUN:
  - Every edge, dcnt increments.
  - At the edge where dcnt==SETTLE: compare Y with EXP_TT[vec_idx].
  - On mismatch: set fail_mask[vec_idx] and increment err_cnt.
  - Y values other than 0/1 count as a mismatch (simulation).
  - Y is ignored at all other dwell cycles, so glitches outside the sample point are invisible.
- Dwell end:
  - At the edge where dcnt==DWELL-1: dcnt->0.
  - If vec_idx<3: vec_idx increments.
  - If vec_idx==3: go to FINISH, busy->0, vec_idx->0.
- FINISH:
  - Lasts exactly one cycle with done=1.
  - pass is registered on entry to FINISH as (final fail_mask==0), including the last vector's sample.
  - Next edge -> IDLE, done->0.
  - start is ignored in FINISH.
- Timing:
  - Start accepted at edge k: RUN spans edges k+1..k+4*DWELL inclusive of the transition edge.
  - busy is high for exactly 4*DWELL cycles, then done is high for 1 cycle.
  - Minimum start-to-start spacing is 4*DWELL+2 cycles, because one IDLE cycle follows FINISH.
- Fixed vector order: 00, 01, 10, 11; A is the MSB.
- start during RUN: ignored; no restart and no effect on counters.
- Reset mid-RUN: sweep is aborted; no done pulse; all outputs return to reset values.
- err_cnt always equals the popcount of fail_mask; it cannot overflow (max 4).

Test Plan (DWELL=4, SETTLE=1):
1. Reset: rst=1 for 2 cycles with start=1 -> A=B=busy=done=pass=0, err_cnt=0, fail_mask=0; no run starts.
2. Y=A&B with default EXP_TT, one-cycle start:
   - A/B go 00,01,10,11, 4 cycles each; busy high 16 cycles.
   - done pulses 1 cycle; pass=1, err_cnt=0, fail_mask=4'b0000.
3. Y=A|B with EXP_TT=4'b1000 -> fail_mask=4'b0110, err_cnt=2, pass=0 at done.
4. Y stuck at 1 -> fail_mask=4'b0111, err_cnt=3, pass=0.
   - Then Y=A&B with a wrong Y forced only at dcnt=0 of each vector -> pass=1 (glitches outside the sample point are ignored).
5. start held high continuously from one cycle before the first run:
   - Exactly one run per 18 cycles.
   - Pattern is 16 busy + 1 done + 1 idle, then busy rises again.
   - Mid-run start pulses have no effect.
6. rst asserted at the 7th RUN cycle (vec_idx=1):
   - Next edge: busy=0, A=B=0, vec_idx=0, fail_mask=0; no done pulse.
   - A new start afterwards completes normally with pass=1.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Stimulus/check stage for 2-input gate blocks: sweeps {A,B} through 00..11,
// samples Y once per vector at a fixed settle offset and accumulates a verdict.
module gate_stim_checker #(
  parameter int         DWELL  = 4,
  parameter int         SETTLE = 1,
  parameter logic [3:0] EXP_TT = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] SETTLE_PT = DW'(SETTLE);
  localparam logic [DW-1:0] DWELL_END = DW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic          mismatch;
  logic [3:0]    mask_nxt;
  logic [2:0]    cnt_nxt;
  logic [1:0]    vec_nxt;

  // Sample result folded in combinationally so the final verdict can include
  // a sample that lands on the same edge as the last dwell end.
  always_comb begin
    mismatch = 1'b0;
    mask_nxt = fail_mask;
    cnt_nxt  = err_cnt;
    vec_nxt  = vec_idx + 2'd1;
    if (state == RUN && dcnt == SETTLE_PT) begin
      mismatch = (Y !== EXP_TT[vec_idx]);
    end
    if (mismatch) begin
      mask_nxt[vec_idx] = 1'b1;
      cnt_nxt           = err_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      vec_idx   <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            dcnt      <= '0;
            vec_idx   <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            fail_mask <= '0;
            err_cnt   <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          fail_mask <= mask_nxt;
          err_cnt   <= cnt_nxt;
          if (dcnt == DWELL_END) begin
            dcnt <= '0;
            if (vec_idx == 2'd3) begin
              state   <= FINISH;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (mask_nxt == 4'd0);
              vec_idx <= '0;
              A       <= 1'b0;
              B       <= 1'b0;
            end else begin
              vec_idx <= vec_nxt;
              A       <= vec_nxt[1];
              B       <= vec_nxt[0];
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
